// File: rtl/gh_pkg.sv
// Shared guitar-game types and constants, used by the chart reader and the note matcher.
package gh_pkg;

  localparam int TW     = 16;
  localparam int LANES  = 5;
  localparam int WINDOW = 100;

  // One chart note: target time in 10 ms ticks plus the required fret mask.
  typedef struct packed {
    logic [TW-1:0]    noteTime;
    logic [LANES-1:0] lanes;
  } note_t;

endpackage

// File: rtl/note_matcher_if.sv
// Bus between the chart reader / player inputs and the note matcher / scorer.
interface note_matcher_if
  import gh_pkg::*;
#(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             note_valid;
  logic             note_ready;
  logic [TW-1:0]    note_time;
  logic [LANES-1:0] note_lanes;
  logic [TW-1:0]    song_time;
  logic [LANES-1:0] btn;
  logic             strum;
  logic             match_en;
  logic [15:0]      dt;
  logic             miss;
  logic             overstrum;
  logic [CW-1:0]    pending;

  modport master (
    output note_valid, note_time, note_lanes, song_time, btn, strum,
    input  note_ready, match_en, dt, miss, overstrum, pending
  );

  modport slave (
    input  note_valid, note_time, note_lanes, song_time, btn, strum,
    output note_ready, match_en, dt, miss, overstrum, pending
  );

endinterface

// File: rtl/note_fifo.sv
// Show-ahead synchronous FIFO of pending chart notes.
module note_fifo
  import gh_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  note_t                  i_data,
  input  logic                   i_pop,
  output note_t                  o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  note_t          r_mem [DEPTH];
  logic [AW-1:0]  r_wrPtr;
  logic [AW-1:0]  r_rdPtr;
  logic [AW:0]    r_count;
  logic           w_doPush;
  logic           w_doPop;

  assign o_full   = (r_count == (AW+1)'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_head   = r_mem[r_rdPtr];
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  // Note storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/note_matcher.sv
// Judges strums against the oldest pending chart note and emits hit/miss/overstrum strobes.
module note_matcher
  import gh_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input logic           clk,
  input logic           reset,
  note_matcher_if.slave bus
);

  note_t          w_head;
  note_t          w_pushData;
  logic           w_full;
  logic           w_empty;
  logic [$clog2(DEPTH):0] w_count;
  logic           w_push;
  logic           w_pop;
  logic           w_strumEvent;
  logic [TW:0]    w_songX;
  logic [TW:0]    w_headX;
  logic [TW:0]    w_diff;
  logic [TW:0]    w_lateLimit;
  logic           w_late;
  logic           w_hit;
  logic           w_expire;

  logic           r_strumQ;
  logic           r_matchEn;
  logic           r_miss;
  logic           r_overstrum;
  logic [15:0]    r_dt;

  assign w_pushData.noteTime = bus.note_time;
  assign w_pushData.lanes    = bus.note_lanes;
  assign w_push              = bus.note_valid && !w_full;

  note_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_pushData),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Timing math is done one bit wider so neither the distance nor the late limit can wrap.
  assign w_songX     = {1'b0, bus.song_time};
  assign w_headX     = {1'b0, w_head.noteTime};
  assign w_diff      = (w_songX >= w_headX) ? (w_songX - w_headX) : (w_headX - w_songX);
  assign w_lateLimit = w_headX + (TW+1)'(WINDOW);
  assign w_late      = (w_songX >= w_lateLimit);

  // A strum event suppresses expiry for this cycle; a failed strum lets the miss fire next cycle.
  assign w_strumEvent = bus.strum && !r_strumQ;
  assign w_hit        = w_strumEvent && !w_empty && (bus.btn == w_head.lanes)
                        && (w_diff < (TW+1)'(WINDOW));
  assign w_expire     = !w_strumEvent && !w_empty && w_late;
  assign w_pop        = w_hit || w_expire;

  // Edge-detect history and registered judgement strobes; strumQ resets high so a held strum is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_strumQ    <= 1'b1;
      r_matchEn   <= 1'b0;
      r_miss      <= 1'b0;
      r_overstrum <= 1'b0;
      r_dt        <= '0;
    end else begin
      r_strumQ    <= bus.strum;
      r_matchEn   <= w_hit;
      r_miss      <= w_expire;
      r_overstrum <= w_strumEvent && !w_hit;
      if (w_hit) r_dt <= 16'(w_diff);
    end
  end

  assign bus.note_ready = !w_full;
  assign bus.match_en   = r_matchEn;
  assign bus.miss       = r_miss;
  assign bus.overstrum  = r_overstrum;
  assign bus.dt         = r_dt;
  assign bus.pending    = w_count;

endmodule

// File: tb/tb_note_matcher.sv
// Directed self-checking bench for note_matcher.
module tb_note_matcher;
  import gh_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  note_matcher_if #(.DEPTH(8)) bus ();

  note_matcher #(.DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold reset for two cycles; strum is left to the caller.
  task automatic applyReset();
    reset = 1'b1;
    bus.note_valid = 1'b0;
    bus.note_time  = '0;
    bus.note_lanes = '0;
    bus.song_time  = '0;
    bus.btn        = '0;
    tick(2);
    reset = 1'b0;
  endtask

  // Offer one note for a single cycle into a non-full FIFO.
  task automatic pushNote(input logic [TW-1:0] t, input logic [LANES-1:0] l);
    bus.note_valid = 1'b1;
    bus.note_time  = t;
    bus.note_lanes = l;
    tick();
    bus.note_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.strum = 1'b0;
    applyReset();
    checks++;
    if (bus.pending !== 4'd0) begin failures++; $display("[TB] FAIL reset_pending got %0d want 0", bus.pending); end
    checks++;
    if ({bus.match_en, bus.miss, bus.overstrum} !== 3'b000) begin failures++; $display("[TB] FAIL reset_strobes got %b want 000", {bus.match_en, bus.miss, bus.overstrum}); end
    checks++;
    if (bus.dt !== 16'd0) begin failures++; $display("[TB] FAIL reset_dt got %0d want 0", bus.dt); end
    checks++;
    if (bus.note_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got %b want 1", bus.note_ready); end
  endtask

  task automatic test_exact_hit();
    bus.strum = 1'b0;
    applyReset();
    pushNote(16'd500, 5'b00001);
    checks++;
    if (bus.pending !== 4'd1) begin failures++; $display("[TB] FAIL hit_pending_pre got %0d want 1", bus.pending); end
    bus.song_time = 16'd503;
    bus.btn       = 5'b00001;
    bus.strum     = 1'b1;
    tick();
    checks++;
    if ({bus.match_en, bus.miss, bus.overstrum} !== 3'b100) begin failures++; $display("[TB] FAIL hit_strobes got %b want 100", {bus.match_en, bus.miss, bus.overstrum}); end
    checks++;
    if (bus.dt !== 16'd3) begin failures++; $display("[TB] FAIL hit_dt got %0d want 3", bus.dt); end
    checks++;
    if (bus.pending !== 4'd0) begin failures++; $display("[TB] FAIL hit_pending_post got %0d want 0", bus.pending); end
    tick();
    checks++;
    if (bus.match_en !== 1'b0) begin failures++; $display("[TB] FAIL hit_one_cycle got %b want 0", bus.match_en); end
    checks++;
    if (bus.dt !== 16'd3) begin failures++; $display("[TB] FAIL hit_dt_hold got %0d want 3", bus.dt); end
    bus.strum = 1'b0;
    tick();
  endtask

  task automatic test_chord_mismatch();
    bus.strum = 1'b0;
    applyReset();
    pushNote(16'd500, 5'b00011);
    bus.song_time = 16'd500;
    bus.btn       = 5'b00001;
    bus.strum     = 1'b1;
    tick();
    checks++;
    if ({bus.match_en, bus.miss, bus.overstrum} !== 3'b001) begin failures++; $display("[TB] FAIL chord_wrong_strobes got %b want 001", {bus.match_en, bus.miss, bus.overstrum}); end
    checks++;
    if (bus.pending !== 4'd1) begin failures++; $display("[TB] FAIL chord_no_pop got %0d want 1", bus.pending); end
    bus.strum = 1'b0;
    tick();
    checks++;
    if (bus.overstrum !== 1'b0) begin failures++; $display("[TB] FAIL chord_overstrum_clear got %b want 0", bus.overstrum); end
    bus.song_time = 16'd540;
    bus.btn       = 5'b00011;
    bus.strum     = 1'b1;
    tick();
    checks++;
    if ({bus.match_en, bus.miss, bus.overstrum} !== 3'b100) begin failures++; $display("[TB] FAIL chord_hit_strobes got %b want 100", {bus.match_en, bus.miss, bus.overstrum}); end
    checks++;
    if (bus.dt !== 16'd40) begin failures++; $display("[TB] FAIL chord_hit_dt got %0d want 40", bus.dt); end
    checks++;
    if (bus.pending !== 4'd0) begin failures++; $display("[TB] FAIL chord_pending got %0d want 0", bus.pending); end
    bus.strum = 1'b0;
    tick();
  endtask

  task automatic test_expiry();
    bus.strum = 1'b0;
    applyReset();
    bus.song_time = 16'd299;
    pushNote(16'd200, 5'b00001);
    tick();
    checks++;
    if (bus.miss !== 1'b0) begin failures++; $display("[TB] FAIL expiry_299 got %b want 0", bus.miss); end
    checks++;
    if (bus.pending !== 4'd1) begin failures++; $display("[TB] FAIL expiry_pending_pre got %0d want 1", bus.pending); end
    bus.song_time = 16'd300;
    tick();
    checks++;
    if ({bus.match_en, bus.miss, bus.overstrum} !== 3'b010) begin failures++; $display("[TB] FAIL expiry_300 got %b want 010", {bus.match_en, bus.miss, bus.overstrum}); end
    checks++;
    if (bus.pending !== 4'd0) begin failures++; $display("[TB] FAIL expiry_pending_post got %0d want 0", bus.pending); end
    tick();
    checks++;
    if (bus.miss !== 1'b0) begin failures++; $display("[TB] FAIL expiry_once got %b want 0", bus.miss); end
    tick(2);
    checks++;
    if (bus.miss !== 1'b0) begin failures++; $display("[TB] FAIL expiry_no_repeat got %b want 0", bus.miss); end
  endtask

  task automatic test_back_to_back();
    bus.strum = 1'b0;
    applyReset();
    bus.song_time = 16'd1000;
    bus.btn       = 5'b00001;
    for (int i = 0; i < 8; i++) begin
      bus.note_valid = 1'b1;
      bus.note_time  = 16'(1000 + i);
      bus.note_lanes = 5'b00001;
      checks++;
      if (bus.note_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_ready_%0d got %b want 1", i, bus.note_ready); end
      tick();
    end
    bus.note_time = 16'd1008;
    checks++;
    if (bus.note_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_ready_full got %b want 0", bus.note_ready); end
    checks++;
    if (bus.pending !== 4'd8) begin failures++; $display("[TB] FAIL bp_pending_full got %0d want 8", bus.pending); end
    tick(2);
    checks++;
    if (bus.pending !== 4'd8) begin failures++; $display("[TB] FAIL bp_held got %0d want 8", bus.pending); end
    bus.strum = 1'b1;
    tick();
    checks++;
    if ({bus.match_en, bus.dt} !== {1'b1, 16'd0}) begin failures++; $display("[TB] FAIL bp_pop_hit got en=%b dt=%0d want en=1 dt=0", bus.match_en, bus.dt); end
    checks++;
    if (bus.pending !== 4'd7) begin failures++; $display("[TB] FAIL bp_no_push_when_full got %0d want 7", bus.pending); end
    checks++;
    if (bus.note_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_ready_reopen got %b want 1", bus.note_ready); end
    bus.strum = 1'b0;
    tick();
    bus.note_valid = 1'b0;
    checks++;
    if (bus.pending !== 4'd8) begin failures++; $display("[TB] FAIL bp_ninth_in got %0d want 8", bus.pending); end
    tick();
  endtask

  task automatic test_held_strum_reset();
    bus.strum = 1'b1;
    applyReset();
    bus.song_time = 16'd500;
    bus.btn       = 5'b00001;
    pushNote(16'd500, 5'b00001);
    tick(2);
    checks++;
    if ({bus.match_en, bus.miss, bus.overstrum} !== 3'b000) begin failures++; $display("[TB] FAIL held_no_strobe got %b want 000", {bus.match_en, bus.miss, bus.overstrum}); end
    checks++;
    if (bus.pending !== 4'd1) begin failures++; $display("[TB] FAIL held_pending got %0d want 1", bus.pending); end
    bus.strum = 1'b0;
    tick();
    bus.strum = 1'b1;
    tick();
    checks++;
    if ({bus.match_en, bus.dt} !== {1'b1, 16'd0}) begin failures++; $display("[TB] FAIL held_restrum got en=%b dt=%0d want en=1 dt=0", bus.match_en, bus.dt); end
    bus.strum = 1'b0;
    tick();
  endtask

  task automatic test_early_empty();
    bus.strum = 1'b0;
    applyReset();
    bus.song_time = 16'd100;
    bus.btn       = 5'b00001;
    pushNote(16'd250, 5'b00001);
    bus.strum = 1'b1;
    tick();
    checks++;
    if ({bus.match_en, bus.miss, bus.overstrum} !== 3'b001) begin failures++; $display("[TB] FAIL early_strobes got %b want 001", {bus.match_en, bus.miss, bus.overstrum}); end
    checks++;
    if (bus.pending !== 4'd1) begin failures++; $display("[TB] FAIL early_no_pop got %0d want 1", bus.pending); end
    bus.strum = 1'b0;
    applyReset();
    tick();
    bus.strum = 1'b1;
    tick();
    checks++;
    if ({bus.match_en, bus.miss, bus.overstrum} !== 3'b001) begin failures++; $display("[TB] FAIL empty_strobes got %b want 001", {bus.match_en, bus.miss, bus.overstrum}); end
    checks++;
    if (bus.pending !== 4'd0) begin failures++; $display("[TB] FAIL empty_pending got %0d want 0", bus.pending); end
    bus.strum = 1'b0;
    tick();
  endtask

  // Run every scenario in order, then report.
  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.strum = 1'b0;
    test_reset();
    test_exact_hit();
    test_chord_mismatch();
    test_expiry();
    test_back_to_back();
    test_held_strum_reset();
    test_early_empty();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/note_matcher.md
Name: note_matcher

Overview:
Judges player strums against the chart and sits directly upstream of the score accumulator. It buffers upcoming chart notes pushed by the chart reader and compares each strum against the oldest pending note. On a hit it emits a one-cycle match strobe with the timing error dt, in 10 ms ticks, which drives the scorer's en/dt inputs. Notes that pass unplayed are retired with a miss strobe.

Parameters:
DEPTH, 8, pending-note FIFO depth (power of two)
LANES, 5, number of fret buttons / lane mask width
TW, 16, time width in 10 ms ticks
WINDOW, 100, hit window half-width in ticks (matches scorer's outermost band)

Ports:
clk  in  1  100 MHz system clock
reset  in  1  synchronous, active-high
note_valid  in  1  chart reader offers a note
note_ready  out  1  FIFO can accept; transfer when valid&&ready
note_time  in  TW  target time of offered note, ticks
note_lanes  in  LANES  required fret mask (chords allowed)
song_time  in  TW  current song position, ticks, monotonic, no wrap
btn  in  LANES  debounced fret levels
strum  in  1  debounced strum level
match_en  out  1  one-cycle hit strobe to scorer
dt  out  16  |song_time - note_time| at hit; valid with match_en
miss  out  1  one-cycle strobe, head note expired unplayed
overstrum  out  1  one-cycle strobe, strum that matched nothing
pending  out  $clog2(DEPTH)+1  notes currently queued

Behaviour:
- Reset: FIFO emptied, pending=0, match_en/miss/overstrum=0, dt=0; strum_q set to 1, so a strum held through reset does not fire.
- Push: note_ready = (pending != DEPTH), driven from registered count. Push occurs on valid&&ready. No push while full, even when a pop happens in the same cycle.
- Strum event: strum && !strum_q, where strum_q is registered strum. One event per rising edge.
- Definitions: head = oldest FIFO entry. diff = |song_time - head.time|, computed at TW+1 bits. late = song_time >= head.time + WINDOW, sum computed at TW+1 bits with no wrap.
- Evaluation, every cycle, registered outputs, latency 1:
  - Strum event && nonempty && btn == head.lanes && diff < WINDOW: next cycle match_en=1, dt=diff zero-extended; pop head.
  - Strum event, otherwise (empty, wrong frets, too early, or too late): next cycle overstrum=1; no pop.
  - No strum event && nonempty && late: next cycle miss=1; pop head.
- Priority: match and late are mutually exclusive because diff<WINDOW excludes late. A strum event that fails to match suppresses the miss check that cycle; the miss fires on the next cycle instead.
- At most one pop per cycle; exactly one of match_en/miss/overstrum can be high in a cycle.
- Simultaneous push and pop when not full: both occur; pending unchanged.
- Push into empty FIFO: the note is head on the following cycle; not evaluated in the push cycle.
- dt holds its last value when match_en=0.
- Notes must be pushed in nondecreasing note_time order; the block does not reorder.
- Reset mid-song discards all pending notes with no miss strobes.

Decomposition:
- Shared package gh_pkg: TW, LANES, WINDOW constants, and the note_t typedef {time[TW], lanes[LANES]}, shared with the chart reader.
- Sub-module note_fifo: synchronous FIFO of note_t with push/pop, full/empty and count, show-ahead head output.
- Matcher logic, edge detect and strobes stay in note_matcher.

Test Plan:
- Exact hit: push {time=500, lanes=00001}; btn=00001; strum rises at song_time=503 -> one cycle later match_en=1, dt=3; pending 1->0; scorer adds 100.
- Chord mismatch: head lanes=00011, btn=00001, strum at song_time=500 -> overstrum=1, no pop; then btn=00011, strum again at 540 -> match_en=1, dt=40.
- Expiry: push {time=200}; no strum; song_time steps 299 -> 300 -> miss=1 for exactly one cycle at 300+1; pending=0; no further miss.
- Backpressure: push 9 notes back-to-back -> note_ready falls after 8 accepted; 9th held until a pop; pending never exceeds 8.
- Held strum across reset: strum=1 during and after reset with matching head -> no strobe until strum falls and rises again.
- Early and empty strums: strum at song_time=100 with head time=250 -> overstrum, no pop; strum with FIFO empty -> overstrum; match_en stays 0 in both cases.
